// File: rtl/raster_pkg.sv
// Shared types for the triangle raster walker: coordinate, coefficient and
// edge-value widths plus the walker FSM state encoding.
package raster_pkg;

    typedef logic        [8:0]  xcoord_t;
    typedef logic        [7:0]  ycoord_t;
    typedef logic signed [9:0]  coef_t;
    typedef logic signed [17:0] const_t;
    typedef logic signed [20:0] edge_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_SUM  = 3'd2,
        ST_WALK = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam int NUM_EDGES = 3;

endpackage

// File: rtl/tri_raster_walk_if.sv
// Covered-pixel valid/ready stream from the raster walker to the fragment stage.
interface tri_raster_walk_if;
    import raster_pkg::*;

    logic    pix_valid;
    logic    pix_ready;
    xcoord_t pix_x;
    ycoord_t pix_y;

    modport master (output pix_valid, output pix_x, output pix_y, input  pix_ready);
    modport slave  (input  pix_valid, input  pix_x, input  pix_y, output pix_ready);

endinterface

// File: rtl/edge_stepper.sv
// One edge function E = a*x + b*y + c: computes the box-corner value, then
// steps it incrementally along x and from row to row; exposes sign/zero flags.
module edge_stepper
    import raster_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    mul_en,
    input  logic    init_en,
    input  logic    step_x,
    input  logic    step_row,
    input  coef_t   a,
    input  coef_t   b,
    input  const_t  c,
    input  xcoord_t x0,
    input  ycoord_t y0,
    output logic    e_neg,
    output logic    e_zero
);

    edge_t a_ext_s, b_ext_s, c_ext_s, x0_ext_s, y0_ext_s;
    edge_t prod_x_q, prod_x_d, prod_y_q, prod_y_d;
    edge_t e_q, e_d, row_e_q, row_e_d;

    // Sign-extend coefficients, zero-extend coordinates, select the next E values
    always_comb begin
        a_ext_s  = {{11{a[9]}}, a};
        b_ext_s  = {{11{b[9]}}, b};
        c_ext_s  = {{3{c[17]}}, c};
        x0_ext_s = {12'd0, x0};
        y0_ext_s = {13'd0, y0};
        prod_x_d = prod_x_q;
        prod_y_d = prod_y_q;
        e_d      = e_q;
        row_e_d  = row_e_q;
        if (mul_en) begin
            prod_x_d = a_ext_s * x0_ext_s;
            prod_y_d = b_ext_s * y0_ext_s;
        end else begin
            prod_x_d = prod_x_q;
            prod_y_d = prod_y_q;
        end
        if (init_en) begin
            e_d     = prod_x_q + prod_y_q + c_ext_s;
            row_e_d = prod_x_q + prod_y_q + c_ext_s;
        end else if (step_x) begin
            e_d = e_q + a_ext_s;
        end else if (step_row) begin
            row_e_d = row_e_q + b_ext_s;
            e_d     = row_e_q + b_ext_s;
        end else begin
            e_d     = e_q;
            row_e_d = row_e_q;
        end
    end

    // Product and edge-value registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_x_q <= 21'sd0;
            prod_y_q <= 21'sd0;
            e_q      <= 21'sd0;
            row_e_q  <= 21'sd0;
        end else begin
            prod_x_q <= prod_x_d;
            prod_y_q <= prod_y_d;
            e_q      <= e_d;
            row_e_q  <= row_e_d;
        end
    end

    assign e_neg  = e_q[20];
    assign e_zero = (e_q == 21'sd0);

endmodule

// File: rtl/tri_raster_walk.sv
// Walks a triangle's bounding box row-major and streams covered pixels.
// Build option RASTER_BOTH_WINDING_EN also accepts clockwise triangles.
module tri_raster_walk
    import raster_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    edge_done,
    input  coef_t   a1,
    input  coef_t   b1,
    input  coef_t   a2,
    input  coef_t   b2,
    input  coef_t   a3,
    input  coef_t   b3,
    input  const_t  c1,
    input  const_t  c2,
    input  const_t  c3,
    input  xcoord_t bbxi,
    input  xcoord_t bbxf,
    input  ycoord_t bbyi,
    input  ycoord_t bbyf,
    tri_raster_walk_if.master pix,
    output logic    raster_busy,
    output logic    raster_done
);

    state_t  state_q, state_d;
    coef_t   a_q [NUM_EDGES];
    coef_t   a_d [NUM_EDGES];
    coef_t   b_q [NUM_EDGES];
    coef_t   b_d [NUM_EDGES];
    const_t  c_q [NUM_EDGES];
    const_t  c_d [NUM_EDGES];
    xcoord_t bbxi_q, bbxi_d, bbxf_q, bbxf_d, x_q, x_d, pix_x_q, pix_x_d;
    ycoord_t bbyi_q, bbyi_d, bbyf_q, bbyf_d, y_q, y_d, pix_y_q, pix_y_d;
    logic    pix_valid_q, pix_valid_d, busy_q, busy_d, done_q, done_d;

    logic [NUM_EDGES-1:0] e_neg_s, e_zero_s;
    logic stall_s, x_last_s, y_last_s, advance_s, inside_s;
    logic mul_en_s, init_en_s, step_x_s, step_row_s;

    // Walker control and the point-coverage decision
    always_comb begin
        stall_s    = pix_valid_q & ~pix.pix_ready;
        x_last_s   = (x_q >= bbxf_q);
        y_last_s   = (y_q >= bbyf_q);
        advance_s  = (state_q == ST_WALK) & ~stall_s;
        mul_en_s   = (state_q == ST_MUL);
        init_en_s  = (state_q == ST_SUM);
        step_x_s   = advance_s & ~x_last_s;
        step_row_s = advance_s & x_last_s & ~y_last_s;
        inside_s   = &(~e_neg_s | e_zero_s);
`ifdef RASTER_BOTH_WINDING_EN
        inside_s   = inside_s | (&(e_neg_s | e_zero_s));
`endif
    end

    for (genvar i = 0; i < NUM_EDGES; i++) begin : g_edge
        edge_stepper u_edge (
            .clk      (clk),
            .rst      (rst),
            .mul_en   (mul_en_s),
            .init_en  (init_en_s),
            .step_x   (step_x_s),
            .step_row (step_row_s),
            .a        (a_q[i]),
            .b        (b_q[i]),
            .c        (c_q[i]),
            .x0       (bbxi_q),
            .y0       (bbyi_q),
            .e_neg    (e_neg_s[i]),
            .e_zero   (e_zero_s[i])
        );
    end

    // FSM next state, coordinate walk and pixel output register
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        bbxi_d      = bbxi_q;
        bbxf_d      = bbxf_q;
        bbyi_d      = bbyi_q;
        bbyf_d      = bbyf_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_valid_d = pix_valid_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (edge_done) begin
                    a_d[0] = a1;  a_d[1] = a2;  a_d[2] = a3;
                    b_d[0] = b1;  b_d[1] = b2;  b_d[2] = b3;
                    c_d[0] = c1;  c_d[1] = c2;  c_d[2] = c3;
                    bbxi_d  = bbxi;
                    bbxf_d  = bbxf;
                    bbyi_d  = bbyi;
                    bbyf_d  = bbyf;
                    busy_d  = 1'b1;
                    state_d = ST_MUL;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_MUL: state_d = ST_SUM;
            ST_SUM: begin
                x_d     = bbxi_q;
                y_d     = bbyi_q;
                state_d = ST_WALK;
            end
            ST_WALK: begin
                if (!stall_s) begin
                    // Either nothing is pending or it transfers on this edge
                    pix_valid_d = inside_s;
                    if (inside_s) begin
                        pix_x_d = x_q;
                        pix_y_d = y_q;
                    end else begin
                        pix_x_d = pix_x_q;
                        pix_y_d = pix_y_q;
                    end
                    if (!x_last_s) begin
                        x_d = x_q + 9'd1;
                    end else if (!y_last_s) begin
                        x_d = bbxi_q;
                        y_d = y_q + 8'd1;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    state_d = ST_WALK;
                end
            end
            ST_FIN: begin
                if (!stall_s) begin
                    pix_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched triangle and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '{default: '0};
            b_q         <= '{default: '0};
            c_q         <= '{default: '0};
            bbxi_q      <= 9'd0;
            bbxf_q      <= 9'd0;
            bbyi_q      <= 8'd0;
            bbyf_q      <= 8'd0;
            x_q         <= 9'd0;
            y_q         <= 8'd0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 9'd0;
            pix_y_q     <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            bbxi_q      <= bbxi_d;
            bbxf_q      <= bbxf_d;
            bbyi_q      <= bbyi_d;
            bbyf_q      <= bbyf_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pix.pix_valid = pix_valid_q;
    assign pix.pix_x     = pix_x_q;
    assign pix.pix_y     = pix_y_q;
    assign raster_busy   = busy_q;
    assign raster_done   = done_q;

endmodule

// File: tb/tb_tri_raster_walk.sv
// Bench for tri_raster_walk: table of directed and random triangles checked
// against a direct per-pixel evaluation of the edge functions.
`timescale 1ns/1ps
module tb_tri_raster_walk;
    import raster_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    edge_done = 1'b0;
    coef_t   a1 = '0, b1 = '0, a2 = '0, b2 = '0, a3 = '0, b3 = '0;
    const_t  c1 = '0, c2 = '0, c3 = '0;
    xcoord_t bbxi = '0, bbxf = '0;
    ycoord_t bbyi = '0, bbyf = '0;
    logic    raster_busy, raster_done;

    tri_raster_walk_if pix_if();

    tri_raster_walk dut (
        .clk(clk), .rst(rst), .edge_done(edge_done),
        .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
        .c1(c1), .c2(c2), .c3(c3),
        .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
        .pix(pix_if.master),
        .raster_busy(raster_busy), .raster_done(raster_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a1, b1, a2, b2, a3, b3, c1, c2, c3;
        int xi, xf, yi, yf;
        int exp_n;       // expected pixel count, -1 when only the model decides
        int ready_pct;   // probability of pix_ready, 100 = always
        int stall_idx;   // pixel index to hold off for 5 cycles, -1 = none
        int abort_n;     // assert rst after this many pixels, -1 = never
        int inject_cyc;  // cycle of a spurious edge_done, -1 = none
    } vec_t;

    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;
    int   exp_x[$];
    int   exp_y[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic bit model_inside(input int e1, input int e2, input int e3);
        bit pos;
        bit neg;
        pos = (e1 >= 0) && (e2 >= 0) && (e3 >= 0);
        neg = (e1 <= 0) && (e2 <= 0) && (e3 <= 0);
`ifdef RASTER_BOTH_WINDING_EN
        return pos || neg;
`else
        return pos && (neg || !neg);
`endif
    endfunction

    task automatic build_model(input vec_t v);
        exp_x.delete();
        exp_y.delete();
        for (int y = v.yi; y <= v.yf; y++) begin
            for (int x = v.xi; x <= v.xf; x++) begin
                if (model_inside(v.a1 * x + v.b1 * y + v.c1,
                                 v.a2 * x + v.b2 * y + v.c2,
                                 v.a3 * x + v.b3 * y + v.c3)) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                end
            end
        end
    endtask

    task automatic drive_coefs(input vec_t v);
        a1 = coef_t'(v.a1);  b1 = coef_t'(v.b1);
        a2 = coef_t'(v.a2);  b2 = coef_t'(v.b2);
        a3 = coef_t'(v.a3);  b3 = coef_t'(v.b3);
        c1 = const_t'(v.c1); c2 = const_t'(v.c2); c3 = const_t'(v.c3);
        bbxi = xcoord_t'(v.xi); bbxf = xcoord_t'(v.xf);
        bbyi = ycoord_t'(v.yi); bbyf = ycoord_t'(v.yf);
    endtask

    task automatic run_tri(input vec_t v, input string tag);
        int   cnt, n_got, stall_left, wh, done_at, held_x, held_y;
        bit   held, finished, aborted;
        vec_t junk;
        build_model(v);
        wh = (v.xf - v.xi + 1) * (v.yf - v.yi + 1);
        @(posedge clk); #1;
        drive_coefs(v);
        edge_done = 1'b1;
        pix_if.pix_ready = 1'b1;
        @(posedge clk); #1;
        edge_done = 1'b0;
        cnt = 0; n_got = 0; stall_left = 5; done_at = -1;
        held = 1'b0; finished = 1'b0; aborted = 1'b0; held_x = 0; held_y = 0;
        while (!finished && !aborted && cnt < wh * 4 + 200) begin
            if (v.inject_cyc == cnt) begin
                junk = v;
                junk.a1 = 0; junk.b1 = 0; junk.a2 = 0; junk.b2 = 0; junk.a3 = 0; junk.b3 = 0;
                junk.c1 = 0; junk.c2 = 0; junk.c3 = 0; junk.xi = 0; junk.xf = 3; junk.yi = 0; junk.yf = 3;
                drive_coefs(junk);
                edge_done = 1'b1;
            end else begin
                edge_done = 1'b0;
            end
            if (v.stall_idx == n_got && pix_if.pix_valid && stall_left > 0) begin
                pix_if.pix_ready = 1'b0;
                stall_left--;
            end else if (v.ready_pct >= 100) begin
                pix_if.pix_ready = 1'b1;
            end else begin
                pix_if.pix_ready = ($urandom_range(0, 99) < v.ready_pct);
            end
            @(negedge clk);
            if (cnt == 0) check({tag, " busy after accept"}, int'(raster_busy), 1);
            if (held) begin
                check({tag, " stall valid"}, int'(pix_if.pix_valid), 1);
                check({tag, " stall x"}, int'(pix_if.pix_x), held_x);
                check({tag, " stall y"}, int'(pix_if.pix_y), held_y);
            end
            held = 1'b0;
            if (pix_if.pix_valid) begin
                if (pix_if.pix_ready) begin
                    if (n_got < exp_x.size()) begin
                        check({tag, $sformatf(" pix%0d x", n_got)}, int'(pix_if.pix_x), exp_x[n_got]);
                        check({tag, $sformatf(" pix%0d y", n_got)}, int'(pix_if.pix_y), exp_y[n_got]);
                    end else begin
                        check({tag, " extra pixel"}, n_got + 1, exp_x.size());
                    end
                    n_got++;
                    if (n_got == v.abort_n) aborted = 1'b1;
                end else begin
                    held   = 1'b1;
                    held_x = int'(pix_if.pix_x);
                    held_y = int'(pix_if.pix_y);
                end
            end
            if (raster_done) begin
                finished = 1'b1;
                done_at  = cnt;
            end
            @(posedge clk); #1;
            cnt++;
        end
        edge_done = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            #1;
            check({tag, " abort pix_valid"}, int'(pix_if.pix_valid), 0);
            check({tag, " abort busy"}, int'(raster_busy), 0);
            check({tag, " abort pix_x"}, int'(pix_if.pix_x), 0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                check({tag, " no done after abort"}, int'(raster_done), 0);
            end
            return;
        end
        check({tag, " finished"}, int'(finished), 1);
        check({tag, " pixel count vs model"}, n_got, exp_x.size());
        if (v.exp_n >= 0) check({tag, " pixel count"}, n_got, v.exp_n);
        if (v.ready_pct >= 100 && v.stall_idx < 0 && finished)
            check({tag, " done cycle"}, done_at, wh + 3);
        @(negedge clk);
        check({tag, " done one cycle"}, int'(raster_done), 0);
        check({tag, " busy falls with done"}, int'(raster_busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cx, cy;
        pix_if.pix_ready = 1'b1;
        // a1,b1,a2,b2,a3,b3,c1,c2,c3, xi,xf,yi,yf, exp_n,ready,stall,abort,inject
        vecs[0] = '{0, 4, -4, -4, 4, 0, 0, 16, 0,  0, 4, 0, 4,  15, 100, -1, -1, -1};
`ifdef RASTER_BOTH_WINDING_EN
        vecs[1] = '{0, -4, 4, 4, -4, 0, 0, -16, 0, 0, 4, 0, 4,  15, 100, -1, -1, -1};
`else
        vecs[1] = '{0, -4, 4, 4, -4, 0, 0, -16, 0, 0, 4, 0, 4,  0,  100, -1, -1, -1};
`endif
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,     7, 7, 3, 3,  1,  100, -1, -1, -1};
        vecs[3] = '{0, 4, -4, -4, 4, 0, 0, 16, 0,  0, 4, 0, 4,  15, 100,  1, -1, -1};
        vecs[4] = '{0, 4, -4, -4, 4, 0, 0, 16, 0,  0, 4, 0, 4,  15, 100, -1,  6, -1};
        vecs[5] = '{0, 4, -4, -4, 4, 0, 0, 16, 0,  0, 4, 0, 4,  15, 100, -1, -1, 10};
        for (int i = 6; i < 10; i++) begin
            vecs[i].xi = int'($urandom_range(0, 500));
            vecs[i].xf = vecs[i].xi + int'($urandom_range(0, 7));
            vecs[i].yi = int'($urandom_range(0, 240));
            vecs[i].yf = vecs[i].yi + int'($urandom_range(0, 7));
            cx = (vecs[i].xi + vecs[i].xf) / 2;
            cy = (vecs[i].yi + vecs[i].yf) / 2;
            vecs[i].a1 = int'($urandom_range(0, 16)) - 8;
            vecs[i].b1 = int'($urandom_range(0, 16)) - 8;
            vecs[i].a2 = int'($urandom_range(0, 16)) - 8;
            vecs[i].b2 = int'($urandom_range(0, 16)) - 8;
            vecs[i].a3 = int'($urandom_range(0, 16)) - 8;
            vecs[i].b3 = int'($urandom_range(0, 16)) - 8;
            vecs[i].c1 = -(vecs[i].a1 * cx + vecs[i].b1 * cy) + int'($urandom_range(0, 12)) - 4;
            vecs[i].c2 = -(vecs[i].a2 * cx + vecs[i].b2 * cy) + int'($urandom_range(0, 12)) - 4;
            vecs[i].c3 = -(vecs[i].a3 * cx + vecs[i].b3 * cy) + int'($urandom_range(0, 12)) - 4;
            vecs[i].exp_n      = -1;
            vecs[i].ready_pct  = (i < 8) ? 60 : 100;
            vecs[i].stall_idx  = -1;
            vecs[i].abort_n    = -1;
            vecs[i].inject_cyc = -1;
        end

        #2;
        rst = 1'b1;
        #1;
        check("reset pix_valid", int'(pix_if.pix_valid), 0);
        check("reset pix_x", int'(pix_if.pix_x), 0);
        check("reset pix_y", int'(pix_if.pix_y), 0);
        check("reset busy", int'(raster_busy), 0);
        check("reset done", int'(raster_done), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_tri(vecs[i], $sformatf("v%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
